// File: rtl/bus_node_fifo_if.sv
// Host and bus side signals of one bus node endpoint.
// The master modport drives the strobes; the slave modport is the FIFO node.
interface bus_node_fifo_if #(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               wr_en;
    logic [PCKG_SZ-1:0] wr_data;
    logic               tx_full;
    logic [CNT_W-1:0]   tx_count;
    logic               pndng;
    logic [PCKG_SZ-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [PCKG_SZ-1:0] D_push;
    logic               rd_en;
    logic [PCKG_SZ-1:0] rd_data;
    logic               rx_valid;
    logic [CNT_W-1:0]   rx_count;
    logic [3:0]         err_flags;
    logic [7:0]         drop_cnt;

    modport master (
        output wr_en, wr_data, pop, push, D_push, rd_en,
        input  tx_full, tx_count, pndng, D_pop,
        input  rd_data, rx_valid, rx_count, err_flags, drop_cnt
    );

    modport slave (
        input  wr_en, wr_data, pop, push, D_push, rd_en,
        output tx_full, tx_count, pndng, D_pop,
        output rd_data, rx_valid, rx_count, err_flags, drop_cnt
    );
endinterface

// File: rtl/bus_node_fifo.sv
// Bus endpoint adapter: TX FIFO toward the bus arbiter, RX FIFO toward the host.
// Status flags come straight from the count registers, so no input reaches them combinationally.
module bus_node_fifo #(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) (
    input logic                clk,
    input logic                reset,
    bus_node_fifo_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PCKG_SZ-1:0] r_tx_mem [DEPTH];
    logic [PCKG_SZ-1:0] r_rx_mem [DEPTH];
    logic [PTR_W-1:0]   r_tx_wp;
    logic [PTR_W-1:0]   r_tx_rp;
    logic [PTR_W-1:0]   r_rx_wp;
    logic [PTR_W-1:0]   r_rx_rp;
    logic [CNT_W-1:0]   r_tx_cnt;
    logic [CNT_W-1:0]   r_rx_cnt;
    logic [3:0]         r_err;
    logic [7:0]         r_drop;

    logic w_tx_empty;
    logic w_tx_full;
    logic w_tx_rd;
    logic w_tx_wr;
    logic w_rx_empty;
    logic w_rx_full;
    logic w_rx_rd;
    logic w_rx_wr;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CNT_W'(DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_W'(DEPTH));

    // A full FIFO still takes a write when its head leaves in the same cycle.
    assign w_tx_rd = bus.pop & ~w_tx_empty;
    assign w_tx_wr = bus.wr_en & (~w_tx_full | w_tx_rd);
    assign w_rx_rd = bus.rd_en & ~w_rx_empty;
    assign w_rx_wr = bus.push & (~w_rx_full | bus.rd_en);

    assign bus.tx_full   = w_tx_full;
    assign bus.tx_count  = r_tx_cnt;
    assign bus.pndng     = ~w_tx_empty;
    assign bus.D_pop     = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
    assign bus.rx_valid  = ~w_rx_empty;
    assign bus.rx_count  = r_rx_cnt;
    assign bus.rd_data   = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
    assign bus.err_flags = r_err;
    assign bus.drop_cnt  = r_drop;

    always_ff @(posedge clk) begin
        if (w_tx_wr) r_tx_mem[r_tx_wp] <= bus.wr_data;
        if (w_rx_wr) r_rx_mem[r_rx_wp] <= bus.D_push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_wr) r_tx_wp <= r_tx_wp + PTR_W'(1);
            if (w_tx_rd) r_tx_rp <= r_tx_rp + PTR_W'(1);
            if (w_tx_wr && !w_tx_rd)
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            else if (w_tx_rd && !w_tx_wr)
                r_tx_cnt <= r_tx_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_wr) r_rx_wp <= r_rx_wp + PTR_W'(1);
            if (w_rx_rd) r_rx_rp <= r_rx_rp + PTR_W'(1);
            if (w_rx_wr && !w_rx_rd)
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            else if (w_rx_rd && !w_rx_wr)
                r_rx_cnt <= r_rx_cnt - CNT_W'(1);
        end
    end

    // Sticky bits {rd_udf, rx_ovf, pop_udf, wr_ovf}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err  <= '0;
            r_drop <= '0;
        end else begin
            if (bus.wr_en && !w_tx_wr) r_err[0] <= 1'b1;
            if (bus.pop && w_tx_empty) r_err[1] <= 1'b1;
            if (bus.push && !w_rx_wr) begin
                r_err[2] <= 1'b1;
                if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end
            if (bus.rd_en && w_rx_empty) r_err[3] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_node_fifo.sv
// Directed and random stimulus for bus_node_fifo against a queue reference model.
// Outputs are sampled 1 time unit after the rising clock edge.
module tb_bus_node_fifo;
    localparam int PW = 16;
    localparam int DP = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [PW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    logic [3:0]    m_err;
    int            m_drop;

    bus_node_fifo_if #(.PCKG_SZ(PW), .DEPTH(DP)) bus ();

    bus_node_fifo #(.PCKG_SZ(PW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [PW-1:0] e_dpop;
        logic [PW-1:0] e_rd;
        e_dpop = (txq.size() != 0) ? txq[0] : '0;
        e_rd   = (rxq.size() != 0) ? rxq[0] : '0;
        chk("pndng", 32'(bus.pndng), 32'(txq.size() != 0));
        chk("D_pop", 32'(bus.D_pop), 32'(e_dpop));
        chk("tx_count", 32'(bus.tx_count), 32'(txq.size()));
        chk("tx_full", 32'(bus.tx_full), 32'(txq.size() == DP));
        chk("rx_valid", 32'(bus.rx_valid), 32'(rxq.size() != 0));
        chk("rd_data", 32'(bus.rd_data), 32'(e_rd));
        chk("rx_count", 32'(bus.rx_count), 32'(rxq.size()));
        chk("err_flags", 32'(bus.err_flags), 32'(m_err));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        m_err  = '0;
        m_drop = 0;
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic step(input logic wr, input logic [PW-1:0] wd,
                        input logic p, input logic ps,
                        input logic [PW-1:0] dp, input logic rd);
        bit tpop, twr, rpop, rwr;
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.pop     = p;
        bus.push    = ps;
        bus.D_push  = dp;
        bus.rd_en   = rd;
        tpop = p && (txq.size() > 0);
        twr  = wr && ((txq.size() < DP) || tpop);
        rpop = rd && (rxq.size() > 0);
        rwr  = ps && ((rxq.size() < DP) || rd);
        @(posedge clk);
        #1;
        if (wr && !twr) m_err[0] = 1'b1;
        if (p && !tpop) m_err[1] = 1'b1;
        if (ps && !rwr) begin
            m_err[2] = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        if (rd && !rpop) m_err[3] = 1'b1;
        if (tpop) void'(txq.pop_front());
        if (twr) txq.push_back(wd);
        if (rpop) void'(rxq.pop_front());
        if (rwr) rxq.push_back(dp);
        bus.wr_en = 1'b0;
        bus.pop   = 1'b0;
        bus.push  = 1'b0;
        bus.rd_en = 1'b0;
        check_all();
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst_pndng_async", 32'(bus.pndng), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.pop     = 1'b0;
        bus.push    = 1'b0;
        bus.D_push  = '0;
        bus.rd_en   = 1'b0;
        reset       = 1'b0;
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();

        // single packet through TX
        step(1, 16'h02AB, 0, 0, '0, 0);
        chk("t1_dpop", 32'(bus.D_pop), 32'h02AB);
        chk("t1_cnt", 32'(bus.tx_count), 32'd1);
        step(0, '0, 1, 0, '0, 0);
        chk("t1_pndng", 32'(bus.pndng), 32'd0);

        // fill TX, overflow, drain in order
        for (int i = 0; i < DP; i++) step(1, 16'(i), 0, 0, '0, 0);
        step(1, 16'h0BAD, 0, 0, '0, 0);
        chk("t2_full", 32'(bus.tx_full), 32'd1);
        chk("t2_wrovf", 32'(bus.err_flags[0]), 32'd1);
        for (int i = 0; i < DP; i++) begin
            chk("t2_order", 32'(bus.D_pop), 32'(i));
            step(0, '0, 1, 0, '0, 0);
        end

        // write and pop together while full
        for (int i = 0; i < DP; i++) step(1, 16'h100 + 16'(i), 0, 0, '0, 0);
        step(1, 16'hCAFE, 1, 0, '0, 0);
        chk("t3_cnt", 32'(bus.tx_count), 32'd8);
        for (int i = 0; i < DP; i++) step(0, '0, 1, 0, '0, 0);

        // RX overflow by one
        for (int i = 0; i < DP + 1; i++) step(0, '0, 0, 1, 16'h200 + 16'(i), 0);
        chk("t4_cnt", 32'(bus.rx_count), 32'd8);
        chk("t4_drop", 32'(bus.drop_cnt), 32'd1);
        for (int i = 0; i < DP; i++) begin
            chk("t4_order", 32'(bus.rd_data), 32'h200 + 32'(i));
            step(0, '0, 0, 0, '0, 1);
        end

        // underflow flags only
        pulse_reset();
        step(0, '0, 1, 0, '0, 1);
        chk("t5_err", 32'(bus.err_flags), 32'hA);

        // empty RX push with read; empty TX write with pop
        step(1, 16'h0777, 1, 1, 16'h0555, 1);
        chk("t5b_rxcnt", 32'(bus.rx_count), 32'd1);
        chk("t5b_txcnt", 32'(bus.tx_count), 32'd1);
        step(0, '0, 1, 0, '0, 1);

        // reset with packets in flight
        for (int i = 0; i < 5; i++) step(1, 16'h300 + 16'(i), 0, 0, '0, 0);
        pulse_reset();

        // drop counter saturation
        for (int i = 0; i < DP + 260; i++) step(0, '0, 0, 1, 16'(i), 0);
        chk("sat_drop", 32'(bus.drop_cnt), 32'hFF);
        for (int i = 0; i < DP; i++) step(0, '0, 0, 0, '0, 1);

        // random traffic
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), 16'($urandom),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 55), 16'($urandom),
                 ($urandom_range(0, 99) < 45));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
